// File: rtl/cpu_control_unit_if.sv
// Control/status bundle between the CPU control unit (master) and the Full_CPU datapath (slave).
interface cpu_control_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] mem_dataout;
  logic [DATA_W-1:0] pc_addr;
  logic [DATA_W-1:0] rf_B;
  logic              N;
  logic              Z;
  logic              V;
  logic              C;

  logic              mem_wen;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_datain;
  logic              rf_en;
  logic [1:0]        rf_op;
  logic [2:0]        rf_addr;
  logic [2:0]        rf_readA;
  logic [2:0]        rf_readB;
  logic              pc_en;
  logic              pc_inc0_jum1;
  logic [DATA_W-1:0] pc_ext;
  logic              add0_sub1;
  logic              LHI;
  logic              LLI;
  logic              ext_imm;
  logic [DATA_W-1:0] ext_immB;
  logic              ctro_outR;

  modport master (
    input  mem_dataout, pc_addr, rf_B, N, Z, V, C,
    output mem_wen, mem_ren, mem_addr, mem_datain, rf_en, rf_op, rf_addr,
           rf_readA, rf_readB, pc_en, pc_inc0_jum1, pc_ext, add0_sub1,
           LHI, LLI, ext_imm, ext_immB, ctro_outR
  );

  modport slave (
    output mem_dataout, pc_addr, rf_B, N, Z, V, C,
    input  mem_wen, mem_ren, mem_addr, mem_datain, rf_en, rf_op, rf_addr,
           rf_readA, rf_readB, pc_en, pc_inc0_jum1, pc_ext, add0_sub1,
           LHI, LLI, ext_imm, ext_immB, ctro_outR
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the Full_CPU datapath: FETCH, DECODE, EXEC, (MEM for LD), WB.
// ALU/ST/OUT/JMP/BZ take 4 cycles FETCH-to-FETCH, LD takes 5; HLT or an illegal opcode parks in HALT.
module cpu_control_unit #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  cpu_control_unit_if.master dp,
  output logic               halted,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b00010;
  localparam logic [4:0] OP_LHI  = 5'b00100;
  localparam logic [4:0] OP_LLI  = 5'b00101;
  localparam logic [4:0] OP_LD   = 5'b01000;
  localparam logic [4:0] OP_ST   = 5'b01001;
  localparam logic [4:0] OP_OUT  = 5'b01100;
  localparam logic [4:0] OP_JMP  = 5'b10000;
  localparam logic [4:0] OP_BZ   = 5'b10001;
  localparam logic [4:0] OP_HLT  = 5'b11111;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] st_addr_q, st_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        flags_q, flags_d;     // {n, z, v, c}
  logic              err_q, err_d;

  logic [DATA_W-1:0] cur_ir;
  logic [4:0]        op;
  logic [2:0]        rd, ra, rb;
  logic [7:0]        imm8;
  logic              is_alu, is_legal, wr_rf;

  // During DECODE the word is still on the memory bus, so selects follow it one cycle before ir loads.
  assign cur_ir = (state_q == S_DECODE) ? dp.mem_dataout : ir_q;
  assign op     = cur_ir[15:11];
  assign rd     = cur_ir[10:8];
  assign ra     = cur_ir[7:5];
  assign rb     = cur_ir[4:2];
  assign imm8   = cur_ir[7:0];

  assign is_alu   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  assign is_legal = is_alu || (op == OP_LHI) || (op == OP_LLI) || (op == OP_LD) ||
                    (op == OP_ST) || (op == OP_OUT) || (op == OP_JMP) ||
                    (op == OP_BZ) || (op == OP_HLT);
  assign wr_rf    = is_alu || (op == OP_LHI) || (op == OP_LLI) || (op == OP_LD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      st_addr_q  <= '0;
      mem_addr_q <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      st_addr_q  <= st_addr_d;
      mem_addr_q <= mem_addr_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    st_addr_d     = st_addr_q;
    mem_addr_d    = mem_addr_q;
    flags_d       = flags_q;
    err_d         = err_q;
    dp.mem_ren    = 1'b0;
    dp.mem_wen    = 1'b0;
    dp.mem_datain = '0;
    dp.rf_en      = 1'b0;
    dp.pc_en      = 1'b0;
    dp.ctro_outR  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        dp.mem_ren = 1'b1;
        mem_addr_d = dp.pc_addr[ADDR_W-1:0];
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // rf_B reads rb here; ST needs that address while rf_B carries ra's data in EXEC.
        ir_d      = dp.mem_dataout;
        st_addr_d = dp.rf_B[ADDR_W-1:0];
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        if (op == OP_HLT) begin
          state_d = S_HALT;
        end else if (!is_legal && HALT_ON_ILLEGAL) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else if (op == OP_ST) begin
          dp.mem_wen    = 1'b1;
          mem_addr_d    = st_addr_q;
          dp.mem_datain = dp.rf_B;
        end else if (op == OP_LD) begin
          dp.mem_ren = 1'b1;
          mem_addr_d = dp.rf_B[ADDR_W-1:0];
          state_d    = S_MEM;
        end else if (op == OP_OUT) begin
          dp.ctro_outR = 1'b1;
        end
      end
      S_MEM: begin
        state_d = S_WB;
      end
      S_WB: begin
        dp.rf_en = wr_rf;
        dp.pc_en = 1'b1;
        if (is_alu) flags_d = {dp.N, dp.Z, dp.V, dp.C};
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dp.mem_addr     = mem_addr_d;
  assign dp.rf_addr      = rd;
  assign dp.rf_readA     = (op == OP_LHI) ? rd : ra;
  assign dp.rf_readB     = ((state_q == S_EXEC) && (op == OP_ST)) ? ra : rb;
  assign dp.rf_op        = {1'b0, op == OP_LD};
  assign dp.add0_sub1    = (op == OP_SUB);
  assign dp.LHI          = (op == OP_LHI);
  assign dp.LLI          = (op == OP_LLI);
  assign dp.ext_imm      = (op == OP_ADDI) || (op == OP_LHI) || (op == OP_LLI);
  assign dp.ext_immB     = (op == OP_ADDI) ? {{(DATA_W-5){1'b0}}, imm8[4:0]}
                                           : {{(DATA_W-8){1'b0}}, imm8};
  assign dp.pc_ext       = {{(DATA_W-8){1'b0}}, imm8};
  assign dp.pc_inc0_jum1 = (op == OP_JMP) || ((op == OP_BZ) && flags_q[2]);

  assign halted = (state_q == S_HALT);
  assign err    = err_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, flags_q[3], flags_q[1:0], dp.pc_addr[DATA_W-1:ADDR_W]};

endmodule
